// File: rtl/branch_resolve_ctrl.sv
// Purpose: in-order branch prediction queue between IF and ID, with mispredict recovery and predictor training.
// Latency: redirect/flush/training outputs are registered one cycle after the resolving cycle; recovery lasts FLUSH+REFILL.
// Backpressure: pred_ready drops when the queue is full or recovery is in progress; res_valid is never backpressured.
module branch_resolve_ctrl #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_target,
  input  logic            pred_taken,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            stall,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic            err_underflow,
  output logic [31:0]     mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] QFULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   q_pc_q  [DEPTH];
  logic [XLEN-1:0]   q_tgt_q [DEPTH];
  logic              q_tk_q  [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              rdy_en_q;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              upd_valid_q, upd_valid_d;
  logic [XLEN-1:0]   upd_pc_q, upd_pc_d;
  logic              upd_taken_q, upd_taken_d;
  logic              err_q, err_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;
  logic              push, pop, mismatch;
  // Predicted direction is kept with the entry for debug; training uses the resolved direction.
  logic              unused_head_taken;

  assign unused_head_taken = q_tk_q[rd_ptr_q];

  // rdy_en_q holds pred_ready low through reset and for the cycle rst is released.
  assign pred_ready = rdy_en_q && (state_q == RUN) && (count_q < QFULL);

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign stall          = stall_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign err_underflow  = err_q;
  assign mispredict_cnt = mispredict_cnt_q;

  // Next-state: queue bookkeeping, head compare, recovery sequencing and training.
  always_comb begin
    push             = pred_valid && pred_ready;
    pop              = res_valid && (state_q == RUN) && (count_q != '0);
    mismatch         = pop && (res_target != q_tgt_q[rd_ptr_q]);
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    stall_d          = stall_q;
    upd_valid_d      = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    err_d            = err_q;
    mispredict_cnt_d = mispredict_cnt_q;
    case (state_q)
      RUN: begin
        stall_d = 1'b0;
        if (res_valid && (count_q == '0)) err_d = 1'b1;
        if (pop) begin
          upd_valid_d = 1'b1;
          upd_pc_d    = q_pc_q[rd_ptr_q];
          upd_taken_d = res_taken;
        end
        if (mismatch) begin
          // Everything younger than the head is wrong-path, including a same-cycle push.
          state_d          = FLUSH;
          wr_ptr_d         = '0;
          rd_ptr_d         = '0;
          count_d          = '0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = res_target;
          flush_d          = 1'b1;
          stall_d          = 1'b1;
          if (mispredict_cnt_q != 32'hFFFF_FFFF) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
          if (push && !pop)      count_d = count_q + (AW + 1)'(1);
          else if (pop && !push) count_d = count_q - (AW + 1)'(1);
        end
      end
      FLUSH: begin
        state_d = REFILL;
        stall_d = 1'b1;
      end
      REFILL: begin
        state_d = RUN;
        stall_d = 1'b0;
      end
      default: begin
        state_d = RUN;
        stall_d = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rdy_en_q         <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      err_q            <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rdy_en_q         <= 1'b1;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      err_q            <= err_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Queue storage; a write during a mispredict is harmless since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]  <= pred_pc;
      q_tgt_q[wr_ptr_q] <= pred_target;
      q_tk_q[wr_ptr_q]  <= pred_taken;
    end
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences branch prediction and recovery between IF and ID.
- Keeps an in-order queue of in-flight predictions issued by the IF-stage predictor.
- Checks each ID-stage resolution against the oldest queued prediction.
- On a mispredict, drives a registered redirect, pipeline flush and stall sequence, and emits a training update to the predictor's pattern table for every resolved branch.

Parameters:
XLEN, 64, PC / target width
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  IF issued a branch prediction this cycle
pred_pc  in  XLEN  fetch PC of predicted branch
pred_target  in  XLEN  predicted next PC
pred_taken  in  1  predicted direction
pred_ready  out  1  queue can accept a push; IF holds when low
res_valid  in  1  ID resolved the oldest in-flight branch
res_target  in  XLEN  correct next PC
res_taken  in  1  actual direction
redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  XLEN  correct PC after mispredict
flush  out  1  kill IF/ID contents
stall  out  1  hold fetch during recovery
upd_valid  out  1  train predictor this cycle
upd_pc  out  XLEN  branch PC to train
upd_taken  out  1  actual direction for training
err_underflow  out  1  sticky: resolution arrived with empty queue
mispredict_cnt  out  32  saturating mispredict counter

Behaviour:
- Reset values:
  - All outputs 0.
  - Queue empty; rd/wr pointers and count 0.
  - FSM in RUN.
  - pred_ready=1 one cycle after rst deasserts.
- Reset mid-recovery returns to RUN and clears the queue.
- Queue: FIFO of {pc, target, taken}. Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- pred_ready = (state==RUN) && (count<DEPTH), combinational from registers.
- Push occurs when pred_valid && pred_ready.
- Pop occurs when res_valid && state==RUN && count!=0.
  - Push and pop may coincide, including at full. At full pred_ready=0, so only the pop occurs.
- res_valid in RUN with count==0: ignored, err_underflow set (stays set until rst).
- Compare on pop: mismatch = (res_target != head.target).
- Training (every pop, registered, cycle N+1):
  - upd_valid=1
  - upd_pc=head.pc
  - upd_taken=res_taken
- FSM states RUN, FLUSH, REFILL:
  - RUN: on pop with no mismatch, stay in RUN. On pop with mismatch in cycle N, go to FLUSH.
  - FLUSH (cycle N+1):
    - redirect_valid=1, flush=1, stall=1, redirect_pc=res_target captured at N.
    - Queue fully cleared; any push in cycle N is discarded as wrong-path.
    - mispredict_cnt += 1, saturating at 0xFFFFFFFF.
    - Next state REFILL.
  - REFILL (N+2): stall=1, redirect_valid=0, flush=0. Next state RUN.
  - RUN again at N+3: pred_ready reasserts.
- res_valid and pred_valid are ignored in FLUSH/REFILL. A res_valid there does not set err_underflow.
- redirect_pc holds its last value outside FLUSH.
- flush and redirect_valid are never asserted outside FLUSH.
- stall=1 in FLUSH and REFILL only.
- No combinational path from res_* to any output; all outputs except pred_ready are registered.

Test Plan:
1. Reset, then push 3 predictions (pc 0x100/0x200/0x300, targets 0x140/0x104/0x340), then resolve all with matching targets. Required: 3 upd pulses with upd_pc 0x100, 0x200, 0x300 in order; redirect_valid and flush never set; mispredict_cnt=0.
2. Push DEPTH=4 predictions. Required: pred_ready=0 after the 4th. A 5th pred_valid is dropped. Simultaneous res_valid pops; pred_ready=1 next cycle; count ends at 3.
3. Mispredict on head (target 0x140, res_target 0x104) with a same-cycle push. Required:
   - N+1: redirect_valid=1, flush=1, stall=1, redirect_pc=0x104, mispredict_cnt=1, queue empty (pushed entry dropped).
   - N+2: stall=1 only.
   - N+3: pred_ready=1.
4. res_valid with empty queue. Required: err_underflow=1 and sticky, no upd_valid, no state change. res_valid during FLUSH: no effect.
5. Assert rst in the REFILL state. Required: next cycle all outputs 0, state RUN, pred_ready=1 one cycle after rst deasserts.
6. Force mispredict_cnt to 0xFFFFFFFF (hierarchical deposit), then mispredict. Required: counter stays 0xFFFFFFFF.
